// File: rtl/apb_rr_master_ctrl.sv
// apb_rr_master_ctrl
//   Shares one APB master port among NUM_REQ requesters with round-robin
//   arbitration. Each captured request runs as one APB transfer: SETUP for
//   one cycle, then ACCESS until PREADY (or until the wait-state timeout).
//
// Ports
//   PCLK, PRESETn         clock, asynchronous active-low reset
//   req_valid/req_ack     per-requester request / one-cycle capture pulse
//   req_write/addr/wdata/strb  packed per-requester request fields
//   rsp_valid             one-cycle response pulse to the owning requester
//   rsp_rdata, rsp_err    response data / error (PSLVERR, timeout, parity)
//   PSEL..PSTRB           APB master outputs
//   PREADY, PSLVERR, PRDATA  APB slave responses
//   PADDRCHK, PWDATACHK, PSTRBCHK, PRDATACHK  APB parity signals
//   dbg_state             current FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
// Configuration
//   APB_PARITY_EN  defined: odd parity per byte is generated on PADDR/PWDATA
//                  (and over PSTRB), and PRDATACHK is checked on reads.
//                  undefined: parity outputs are 0 and PRDATACHK is ignored.
//
// Request handshake: a requester raises req_valid and holds it, with its
// fields stable, until it sees req_ack. The ack is a one-cycle pulse in the
// IDLE cycle where the request wins arbitration; the fields are captured on
// that same clock edge. A req_valid dropped before its ack is never captured.
module apb_rr_master_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic                           PREADY,
  input  logic                           PSLVERR,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  output logic [ADDR_WIDTH/8-1:0]        PADDRCHK,
  output logic [DATA_WIDTH/8-1:0]        PWDATACHK,
  output logic                           PSTRBCHK,
  input  logic [DATA_WIDTH/8-1:0]        PRDATACHK,
  output logic [1:0]                     dbg_state
);

  localparam int IDXW     = $clog2(NUM_REQ);
  localparam int SW       = DATA_WIDTH / 8;
  localparam int AB       = ADDR_WIDTH / 8;
  localparam int CW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [IDXW-1:0]       gnt_q, gnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]    ack_c;
  logic [IDXW-1:0]       pick;
  logic [IDXW-1:0]       gnt_next;
  logic                  tmo_hit;
  logic                  rd_par_err;

  // First pending requester at or after the pointer, wrapping. Scanning from
  // the far end down lets the closest candidate overwrite the others.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDXW-1:0]    p);
    logic [IDXW-1:0] r;
    int              i;
    r = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      i = int'(p) + k;
      if (i >= NUM_REQ) i = i - NUM_REQ;
      if (v[IDXW'(i)]) r = IDXW'(i);
    end
    return r;
  endfunction

  assign pick     = rr_pick(req_valid, ptr_q);
  assign gnt_next = (gnt_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_q + IDXW'(1);
  // Fires on the ACCESS cycle that would be the TIMEOUT_CYC-th with PREADY low.
  assign tmo_hit  = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TMO_LAST));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    ack_c       = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          ack_c[pick] = 1'b1;
          gnt_d       = pick;
          pwrite_d    = req_write[pick];
          paddr_d     = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d    = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          pstrb_d     = req_write[pick] ? req_strb[pick*SW +: SW] : '0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Completion is checked first so PREADY on the last allowed cycle wins.
        if (PREADY) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : PRDATA;
          rsp_err_d          = PSLVERR | (~pwrite_q & rd_par_err);
          ptr_d              = gnt_next;
          state_d            = ST_IDLE;
        end else if (tmo_hit) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d          = 1'b1;
          ptr_d              = gnt_next;
          state_d            = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_PARITY_EN
  logic [AB-1:0] paddrchk_q, paddrchk_d;
  logic [SW-1:0] pwdatachk_q, pwdatachk_d;
  logic          pstrbchk_q, pstrbchk_d;

  function automatic logic [AB-1:0] addr_par(input logic [ADDR_WIDTH-1:0] v);
    logic [AB-1:0] r;
    for (int i = 0; i < AB; i++) r[i] = ~^v[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [SW-1:0] data_par(input logic [DATA_WIDTH-1:0] v);
    logic [SW-1:0] r;
    for (int i = 0; i < SW; i++) r[i] = ~^v[i*8 +: 8];
    return r;
  endfunction

  // Parity follows the next-state data so it lands in the same cycle as it.
  assign paddrchk_d  = addr_par(paddr_d);
  assign pwdatachk_d = data_par(pwdata_d);
  assign pstrbchk_d  = ~^pstrb_d;
  assign rd_par_err  = (PRDATACHK != data_par(PRDATA));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddrchk_q  <= '0;
      pwdatachk_q <= '0;
      pstrbchk_q  <= 1'b0;
    end else begin
      paddrchk_q  <= paddrchk_d;
      pwdatachk_q <= pwdatachk_d;
      pstrbchk_q  <= pstrbchk_d;
    end
  end

  assign PADDRCHK  = paddrchk_q;
  assign PWDATACHK = pwdatachk_q;
  assign PSTRBCHK  = pstrbchk_q;
`else
  logic unused_prdatachk;
  assign unused_prdatachk = ^PRDATACHK;
  assign rd_par_err       = 1'b0;
  assign PADDRCHK         = '0;
  assign PWDATACHK        = '0;
  assign PSTRBCHK         = 1'b0;
`endif

  // The grant is combinational from IDLE, so it is forced low during reset.
  assign req_ack   = PRESETn ? ack_c : '0;
  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_rr_master_ctrl.sv
// Testbench for apb_rr_master_ctrl (NUM_REQ=4, 32-bit address/data,
// TIMEOUT_CYC=8). Inputs are driven on the falling edge and outputs sampled
// there too, away from the active rising edge. Expected responses are queued
// when a request is issued and popped when rsp_valid is due.
module tb_apb_rr_master_ctrl;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
  localparam int RW  = 2 + 1 + DW;

`ifdef APB_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              PCLK;
  logic              PRESETn;
  logic [NR-1:0]     req_valid, req_ack, req_write, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
  logic              rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, PSTRBCHK;
  logic [AW-1:0]     PADDR;
  logic [SW-1:0]     PSTRB, PWDATACHK, PRDATACHK;
  logic [AW/8-1:0]   PADDRCHK;
  logic [1:0]        dbg_state;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_rr_master_ctrl #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ack(req_ack), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .PADDRCHK(PADDRCHK), .PWDATACHK(PWDATACHK),
    .PSTRBCHK(PSTRBCHK), .PRDATACHK(PRDATACHK), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            n_checks;
  int            n_errs;
  logic [RW-1:0] exp_q[$];   // {requester[1:0], err, rdata}

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] par(input logic [DW-1:0] d);
    logic [SW-1:0] r;
    for (int i = 0; i < SW; i++) r[i] = ~^d[i*8 +: 8];
    return r;
  endfunction

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic check_rsp();
    logic [RW-1:0] e;
    logic [NR-1:0] oh;
    chk("sb_depth", DW'(exp_q.size()), DW'(1));
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      oh = NR'(1) << e[RW-1 -: 2];
      chk("rsp_valid", DW'(rsp_valid), DW'(oh));
      chk("rsp_err", DW'(rsp_err), DW'(e[DW]));
      chk("rsp_rdata", rsp_rdata, e[DW-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge with the DUT in IDLE and req_valid[g] already
  // high (and g expected to win). Plays the slave side for the whole transfer.
  task automatic serve(input int g, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       input int waits, input logic [DW-1:0] rd,
                       input logic slverr, input bit stuck, input bit badpar,
                       input bit drop);
    logic [NR-1:0] oh;
    logic [SW-1:0] e_strb;
    logic          e_err;
    logic [DW-1:0] e_rd;
    int            n_acc;
    req_write[g]             = wr;
    req_addr[g*AW +: AW]     = a;
    req_wdata[g*DW +: DW]    = wd;
    req_strb[g*SW +: SW]     = st;
    oh     = NR'(1) << g;
    e_strb = wr ? st : '0;
    n_acc  = stuck ? TMO : waits + 1;
    e_err  = stuck | slverr | (badpar & ~wr & PAR_EN);
    e_rd   = (stuck | wr) ? '0 : rd;
    exp_q.push_back({2'(g), e_err, e_rd});
    #1;
    chk("req_ack", DW'(req_ack), DW'(oh));
    tick();
    if (drop) req_valid[g] = 1'b0;
    chk("setup_phase", DW'({PSEL, PENABLE}), DW'(2'b10));
    chk("setup_ack_low", DW'(req_ack), '0);
    chk("pwrite", DW'(PWRITE), DW'(wr));
    chk("paddr", PADDR, a);
    chk("pstrb", DW'(PSTRB), DW'(e_strb));
    chk("paddrchk", DW'(PADDRCHK), DW'(PAR_EN ? par(a) : '0));
    chk("pstrbchk", DW'(PSTRBCHK), DW'(PAR_EN ? ~^e_strb : 1'b0));
    if (wr) begin
      chk("pwdata", PWDATA, wd);
      chk("pwdatachk", DW'(PWDATACHK), DW'(PAR_EN ? par(wd) : '0));
    end
    PRDATA    = rd;
    PRDATACHK = par(rd) ^ {{(SW-1){1'b0}}, badpar};
    PSLVERR   = slverr;
    PREADY    = 1'b0;
    for (int c = 0; c < n_acc; c++) begin
      tick();
      chk("access_phase", DW'({PSEL, PENABLE}), DW'(2'b11));
      chk("access_paddr", PADDR, a);
      chk("no_early_rsp", DW'(rsp_valid), '0);
      PREADY = !stuck && (c == waits);
    end
    tick();
    chk("end_phase", DW'({PSEL, PENABLE}), '0);
    check_rsp();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errs);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_checks  = 0;
    n_errs    = 0;
    PRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    PRDATACHK = '0;

    // Reset: all outputs low even with every requester pending.
    req_valid = 4'hF;
    tick();
    tick();
    chk("rst_ack", DW'(req_ack), '0);
    chk("rst_psel", DW'({PSEL, PENABLE}), '0);
    chk("rst_rsp", DW'(rsp_valid), '0);
    chk("rst_paddr", PADDR, '0);
    chk("rst_pstrbchk", DW'(PSTRBCHK), '0);
    chk("rst_state", DW'(dbg_state), '0);
    req_valid = '0;
    PRESETn   = 1'b1;
    tick();
    chk("idle_psel", DW'(PSEL), '0);

    // Single zero-wait write from requester 0.
    req_valid = 4'b0001;
    serve(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // Read from requester 2 with three wait states (pointer is now 1).
    req_valid = 4'b0100;
    serve(2, 1'b0, 32'h40, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // Slave error on a write from requester 3; pointer wraps back to 0.
    req_valid = 4'b1000;
    serve(3, 1'b1, 32'h80, 32'h5555_AAAA, 4'h3, 1, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // Fairness: all four requesters held for eight transfers.
    req_valid = 4'hF;
    for (int t = 0; t < 8; t++) begin
      serve(t % NR, 1'($urandom_range(0, 1)), $urandom, $urandom,
            SW'($urandom_range(1, 15)), int'($urandom_range(0, 2)), $urandom,
            1'b0, 1'b0, 1'b0, 1'b0);
    end
    req_valid = '0;

    // Timeout: PREADY stuck low on a read from requester 1.
    req_valid = 4'b0010;
    serve(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b1);
    req_valid = '0;

    // PREADY rises on the last ACCESS cycle before the timeout: completes.
    req_valid = 4'b0010;
    serve(1, 1'b0, 32'h24, 32'h0, 4'h0, TMO - 1, 32'h600D_F00D, 1'b0, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // Address 0x1 (PADDRCHK 4'b1110 when parity is on) and a corrupted PRDATACHK.
    req_valid = 4'b0100;
    serve(2, 1'b0, 32'h0000_0001, 32'h0, 4'h0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1, 1'b1);
    req_valid = '0;

    // Wrap: pointer is 3, requesters 0 and 1 pending -> 0 wins.
    req_valid = 4'b0011;
    serve(0, 1'b1, 32'h44, 32'h0000_00FF, 4'h1, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b0010;
    serve(1, 1'b1, 32'h48, 32'h0000_FF00, 4'h2, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    req_valid = '0;

    // Reset in the middle of ACCESS (pointer is 2, requester 2 granted).
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 32'h0000_0300;
    req_write[2]         = 1'b0;
    #1;
    chk("mid_ack", DW'(req_ack), DW'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    chk("mid_access", DW'({PSEL, PENABLE}), DW'(2'b11));
    #2;
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_async", DW'({PSEL, PENABLE}), '0);
    chk("mid_rst_state", DW'(dbg_state), '0);
    tick();
    chk("mid_rst_no_rsp", DW'(rsp_valid), '0);
    PRESETn = 1'b1;
    tick();
    chk("post_rst_no_rsp", DW'(rsp_valid), '0);
    req_valid = 4'hF;
    serve(0, 1'b0, 32'h0000_0500, 32'h0, 4'h0, 1, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, 1'b1);
    req_valid = '0;
    tick();
    chk("sb_leftover", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
